// File: rtl/ir_rx_pkg.sv
// Shared types and default timing for the IR frame receiver.
// Default timing constants assume a 50 MHz system clock.
package ir_rx_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StData,
        StDone
    } ir_state_e;

    localparam int unsigned LeadMinDef = 230000;  // 4.6 ms
    localparam int unsigned LeadMaxDef = 250000;  // 5.0 ms
    localparam int unsigned BitMinDef  = 20000;   // 0.4 ms
    localparam int unsigned OneMinDef  = 40000;   // 0.8 ms
    localparam int unsigned GapEndDef  = 150000;  // 3.0 ms
    localparam int unsigned FiltLenDef = 4;

endpackage

// File: rtl/ir_frame_receiver_if.sv
// Frame output channel: valid/ready handshake plus frame payload and overrun strobe.
interface ir_frame_if #(
    parameter int unsigned MAX_BITS = 128,
    parameter int unsigned LEN_W    = 8
);
    logic                frame_valid;
    logic                frame_ready;
    logic [MAX_BITS-1:0] frame_data;
    logic [LEN_W-1:0]    frame_len;
    logic                frame_err;
    logic                overrun;

    // Receiver side produces frames
    modport master (
        output frame_valid,
        output frame_data,
        output frame_len,
        output frame_err,
        output overrun,
        input  frame_ready
    );

    // Consumer side accepts frames
    modport slave (
        input  frame_valid,
        input  frame_data,
        input  frame_len,
        input  frame_err,
        input  overrun,
        output frame_ready
    );

endinterface

// File: rtl/ir_rx_filter.sv
// Input conditioning: 2-FF synchroniser followed by a deglitch filter.
// The output level is normalised so that idle is 1 and lead/space is 0
// regardless of receiver polarity. rise/fall pulse in the first cycle of a new level.
module ir_rx_filter #(
    parameter int unsigned FILT_LEN = 4,
    parameter bit          INVERT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
    localparam logic [FCW-1:0] CntLast = FCW'(FILT_LEN - 1);
    // Raw pin level while the line is idle
    localparam logic RawIdle = ~INVERT;

    logic           sync1_q, sync2_q;
    logic           sample;
    logic           level_q, level_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic           rise_q, rise_d;
    logic           fall_q, fall_d;

    assign sample = sync2_q ^ INVERT;

    // Two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= RawIdle;
            sync2_q <= RawIdle;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    // Deglitch: flip the level only after FILT_LEN consecutive disagreeing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sample;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ir_frame_receiver.sv
// IR remote frame receiver: lead detection, pulse-width bit classification,
// frame buffering and a one-deep valid/ready output register with overrun reporting.
module ir_frame_receiver
    import ir_rx_pkg::*;
#(
    parameter int unsigned MAX_BITS = 128,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CNT_W    = 18,
    parameter int unsigned LEAD_MIN = LeadMinDef,
    parameter int unsigned LEAD_MAX = LeadMaxDef,
    parameter int unsigned BIT_MIN  = BitMinDef,
    parameter int unsigned ONE_MIN  = OneMinDef,
    parameter int unsigned GAP_END  = GapEndDef,
    parameter int unsigned FILT_LEN = FiltLenDef,
    parameter bit          INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    output logic       busy,
    ir_frame_if.master frame
);

    localparam logic [CNT_W-1:0] LeadMinW = CNT_W'(LEAD_MIN);
    localparam logic [CNT_W-1:0] LeadMaxW = CNT_W'(LEAD_MAX);
    localparam logic [CNT_W-1:0] BitMinW  = CNT_W'(BIT_MIN);
    localparam logic [CNT_W-1:0] OneMinW  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] GapEndW  = CNT_W'(GAP_END);
    localparam logic [LEN_W-1:0] LastBit  = LEN_W'(MAX_BITS - 1);

    logic level, rise, fall;

    ir_state_e state_q, state_d;

    logic [CNT_W-1:0]    width_q, width_d;
    logic [MAX_BITS-1:0] bits_q, bits_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                err_q, err_d;

    logic                valid_q, valid_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;

    logic is_bit, bit_val, gap_hit, lead_ok;
    logic frame_done, load, drop;

    ir_rx_filter #(
        .FILT_LEN (FILT_LEN),
        .INVERT   (INVERT)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // Width counter: on an edge cycle it still holds the length of the run just ended
    always_comb begin
        width_d = width_q;
        if (rise || fall) begin
            width_d = CNT_W'(1);
        end else if (width_q != '1) begin
            width_d = width_q + 1'b1;
        end
    end

    // A falling edge ends a high pulse; short ones are noise
    assign is_bit  = fall && (width_q >= BitMinW);
    assign bit_val = (width_q >= OneMinW);
    // Rise cycles carry the previous low width, so exclude them from the gap test
    assign gap_hit = level && !rise && (width_q >= GapEndW);
    assign lead_ok = (width_q >= LeadMinW) && (width_q <= LeadMaxW);

    // FSM next state and frame buffer update
    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                bits_d    = '0;
                bit_cnt_d = '0;
                err_d     = 1'b0;
                if (fall) begin
                    state_d = StLead;
                end
            end
            StLead: begin
                if (rise) begin
                    state_d = lead_ok ? StData : StIdle;
                end else if (width_q > LeadMaxW) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (is_bit) begin
                    for (int unsigned i = 0; i < MAX_BITS; i++) begin
                        if (bit_cnt_q == LEN_W'(i)) begin
                            bits_d[i] = bit_val;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end else if (gap_hit) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, width counter and frame buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            width_q   <= '0;
            bits_q    <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            bits_q    <= bits_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
        end
    end

    // Empty frames are discarded silently in DONE
    assign frame_done = (state_q == StDone) && (bit_cnt_q != '0);
    assign load       = frame_done && (!valid_q || frame.frame_ready);
    assign drop       = frame_done && valid_q && !frame.frame_ready;

    // Output register next state: load, accept, or hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        len_d   = len_q;
        ferr_d  = ferr_q;
        ovr_d   = drop;
        if (load) begin
            valid_d = 1'b1;
            data_d  = bits_q;
            len_d   = bit_cnt_q;
            ferr_d  = err_q;
        end else if (valid_q && frame.frame_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            len_q   <= len_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign frame.frame_valid = valid_q;
    assign frame.frame_data  = data_q;
    assign frame.frame_len   = len_q;
    assign frame.frame_err   = ferr_q;
    assign frame.overrun     = ovr_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Scoreboard bench for ir_frame_receiver with small timing parameters.
module tb_ir_frame_receiver;

    localparam int unsigned MB       = 8;
    localparam int unsigned LW       = 8;
    localparam int unsigned LEAD_MIN = 40;
    localparam int unsigned LEAD_MAX = 60;
    localparam int unsigned BIT_MIN  = 5;
    localparam int unsigned ONE_MIN  = 12;
    localparam int          IDLE_LEN = 45;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] len;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data_in = 1'b1;
    logic busy;

    ir_frame_if #(.MAX_BITS(MB), .LEN_W(LW)) fif ();

    ir_frame_receiver #(
        .MAX_BITS (MB),
        .LEN_W    (LW),
        .CNT_W    (18),
        .LEAD_MIN (LEAD_MIN),
        .LEAD_MAX (LEAD_MAX),
        .BIT_MIN  (BIT_MIN),
        .ONE_MIN  (ONE_MIN),
        .GAP_END  (30),
        .FILT_LEN (2),
        .INVERT   (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .busy    (busy),
        .frame   (fif)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   ovr_pending = 0;
    bit   rnd_ready = 1'b0;

    // Current frame description
    int lead_len;
    int npulse;
    int hi_w[16];
    int lo_w[16];
    int gl_at[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: lead window, then classify each high pulse by width
    task automatic predict(output bit has, output exp_t e);
        int cnt;
        has = 1'b0;
        e   = '0;
        cnt = 0;
        if (lead_len >= int'(LEAD_MIN) && lead_len <= int'(LEAD_MAX)) begin
            for (int k = 0; k < npulse; k++) begin
                if (cnt < int'(MB) && hi_w[k] >= int'(BIT_MIN)) begin
                    if (hi_w[k] >= int'(ONE_MIN)) e.data = e.data | (8'd1 << cnt);
                    cnt++;
                end
            end
            if (cnt > 0) begin
                has   = 1'b1;
                e.len = 8'(cnt);
                e.err = (cnt == int'(MB));
            end
        end
    endtask

    task automatic step(input logic v, input int n);
        data_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the current frame, then idle high; optionally raise ready for one cycle
    task automatic send(input int ready_at, output int ovr_at);
        step(1'b0, lead_len);
        for (int k = 0; k < npulse; k++) begin
            if (gl_at[k] > 0) begin
                step(1'b1, gl_at[k]);
                step(1'b0, 1);
                step(1'b1, hi_w[k] - gl_at[k] - 1);
            end else begin
                step(1'b1, hi_w[k]);
            end
            step(1'b0, lo_w[k]);
        end
        data_in = 1'b1;
        ovr_at = -1;
        for (int i = 0; i < IDLE_LEN; i++) begin
            @(posedge clk);
            #1;
            if (fif.overrun && ovr_at < 0) ovr_at = i;
            if (ready_at >= 0) begin
                if (i == ready_at - 1) fif.frame_ready = 1'b1;
                else if (i == ready_at) fif.frame_ready = 1'b0;
            end
        end
    endtask

    task automatic push_and_send();
        bit   has;
        exp_t e;
        int   dummy;
        predict(has, e);
        if (has) exp_q.push_back(e);
        send(-1, dummy);
    endtask

    task automatic set_plain(input int lead, input int n, input int w);
        lead_len = lead;
        npulse   = n;
        for (int k = 0; k < 16; k++) begin
            hi_w[k]  = w;
            lo_w[k]  = 6;
            gl_at[k] = 0;
        end
    endtask

    task automatic gen_random();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
            case ($urandom_range(0, 3))
                0: lead_len = 30;
                1: lead_len = 39;
                2: lead_len = 61;
                default: lead_len = 70;
            endcase
        end else if (r == 1) begin
            lead_len = ($urandom_range(0, 1) == 0) ? 40 : 60;
        end else begin
            lead_len = int'($urandom_range(41, 59));
        end
        npulse = int'($urandom_range(0, 11));
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) hi_w[k] = int'($urandom_range(3, 4));
            else if (r < 5) hi_w[k] = int'($urandom_range(5, 11));
            else hi_w[k] = int'($urandom_range(12, 25));
            lo_w[k] = int'($urandom_range(3, 10));
            gl_at[k] = 0;
            if (hi_w[k] >= 5 && $urandom_range(0, 4) == 0)
                gl_at[k] = int'($urandom_range(2, hi_w[k] - 2));
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(fif.frame_valid), 32'd0);
        check({tag, "_data"}, 32'(fif.frame_data), 32'd0);
        check({tag, "_len"}, 32'(fif.frame_len), 32'd0);
        check({tag, "_err"}, 32'(fif.frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(fif.overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: compares every accepted frame and every overrun against the scoreboard
    exp_t       mon_e;
    bit         hold_prev = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] hold_len;
    logic       hold_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (fif.overrun) begin
                checks++;
                if (ovr_pending == 0) begin
                    errors++;
                    $display("FAIL overrun: got pulse, expected none");
                end else begin
                    ovr_pending--;
                end
            end
            if (hold_prev && fif.frame_valid) begin
                check("hold_data", 32'(fif.frame_data), 32'(hold_data));
                check("hold_len", 32'(fif.frame_len), 32'(hold_len));
                check("hold_err", 32'(fif.frame_err), 32'(hold_err));
            end
            if (fif.frame_valid && fif.frame_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_frame: got data 0x%0h len %0d, expected no frame",
                             fif.frame_data, fif.frame_len);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_data", 32'(fif.frame_data), 32'(mon_e.data));
                    check("frame_len", 32'(fif.frame_len), 32'(mon_e.len));
                    check("frame_err", 32'(fif.frame_err), 32'(mon_e.err));
                end
            end
            hold_prev = fif.frame_valid && !fif.frame_ready;
            hold_data = fif.frame_data;
            hold_len  = fif.frame_len;
            hold_err  = fif.frame_err;
        end
    end

    // Randomised consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) fif.frame_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   has;
        exp_t e;
        int   ovr_b;
        int   ovr_c;

        fif.frame_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step(1'b1, 10);
        rnd_ready = 1'b1;

        // Basic frame: 0,1,0,1
        set_plain(50, 4, 8);
        hi_w[1] = 15;
        hi_w[3] = 15;
        push_and_send();

        // Out-of-window leads yield nothing
        set_plain(30, 2, 15);
        push_and_send();
        check("lead30_busy", 32'(busy), 32'd0);
        set_plain(70, 2, 15);
        push_and_send();
        check("lead70_busy", 32'(busy), 32'd0);

        // Glitch inside a pulse and a 3-cycle noise pulse
        set_plain(50, 3, 15);
        gl_at[0] = 5;
        hi_w[1]  = 3;
        hi_w[2]  = 8;
        push_and_send();

        // Buffer full: 10 one-pulses truncate at 8
        set_plain(50, 10, 15);
        push_and_send();
        check("full_busy", 32'(busy), 32'd0);

        for (int n = 0; n < 40; n++) begin
            gen_random();
            push_and_send();
        end
        wait_drain();

        // Back-pressure: A held, B dropped with overrun
        rnd_ready = 1'b0;
        fif.frame_ready = 1'b0;
        set_plain(50, 3, 8);
        hi_w[0] = 15;
        predict(has, e);
        exp_q.push_back(e);
        send(-1, ovr_b);
        set_plain(50, 5, 15);
        ovr_pending++;
        send(-1, ovr_b);
        check("overrun_seen", 32'(ovr_b >= 0), 32'd1);

        // C finishes while A is accepted in the same cycle: reload, no overrun
        if (ovr_b >= 1) begin
            set_plain(50, 2, 8);
            predict(has, e);
            exp_q.push_back(e);
            send(ovr_b, ovr_c);
            check("reload_no_overrun", 32'(ovr_c), 32'hFFFF_FFFF);
            check("reload_valid", 32'(fif.frame_valid), 32'd1);
        end
        rnd_ready = 1'b1;
        wait_drain();
        check("overrun_pending", 32'(ovr_pending), 32'd0);

        // Reset in the middle of DATA discards the frame
        set_plain(50, 2, 15);
        step(1'b0, lead_len);
        step(1'b1, 15);
        step(1'b0, 6);
        step(1'b1, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        step(1'b1, IDLE_LEN);
        check("midreset_valid", 32'(fif.frame_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);

        set_plain(50, 4, 15);
        hi_w[2] = 8;
        push_and_send();
        wait_drain();
        check("final_overrun_pending", 32'(ovr_pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_frame_receiver.md
Name: ir_frame_receiver

Overview:
Parametrised next-generation IR/AC remote frame receiver. Synchronises and deglitches the raw demodulated IR input, detects a low lead pulse, then classifies each high pulse width as logic 0 or 1. Frame end is a long high gap or a full buffer. Completed frames go to a one-deep output register with a valid/ready handshake, length, and error/overrun reporting. Sits between the IR pin and the command decoder/CPU bridge.

Parameters:
MAX_BITS, 128, frame buffer depth in bits (>=1)
LEN_W, 8, width of frame_len; must hold MAX_BITS
CNT_W, 18, pulse-width counter width; must hold GAP_END and LEAD_MAX
LEAD_MIN, 230000, minimum low lead duration in clk cycles (4.6 ms at 50 MHz)
LEAD_MAX, 250000, low lead longer than this aborts to IDLE
BIT_MIN, 20000, shorter high pulses are ignored as noise
ONE_MIN, 40000, high pulse >= this is a 1; BIT_MIN..ONE_MIN-1 is a 0
GAP_END, 150000, high level reaching this ends the frame
FILT_LEN, 4, consecutive equal synchronised samples required to change the filtered level
INVERT, 0, 1 = input is active-high; 0 = lead/space sensed as low

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
data_in  in  1  raw asynchronous IR receiver output
frame_ready  in  1  consumer accepts the frame when high with frame_valid
frame_valid  out  1  frame_data/len/err hold a completed frame
frame_data  out  MAX_BITS  received bits, bit 0 = first bit, unreceived bits 0
frame_len  out  LEN_W  number of bits received (1..MAX_BITS)
frame_err  out  1  frame ended by buffer full (possible truncation)
overrun  out  1  one-cycle pulse: completed frame dropped because output was still occupied
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters, buffer and filter cleared; filtered level = idle level (high after INVERT).
- Reset mid-frame discards the frame with no output.
- Input path: 2-FF synchroniser, then deglitch. The filtered level changes only after FILT_LEN identical samples. Fixed latency is 2+FILT_LEN cycles, and all widths are measured on the filtered level.
- Width counter: counts cycles at the current level, clears on every filtered edge, saturates at all-ones (no wrap).
- FSM states:
  - IDLE -> LEAD on filtered falling edge.
  - LEAD: on rising edge, go to DATA if LEAD_MIN <= width <= LEAD_MAX, else IDLE. If width exceeds LEAD_MAX while still low, go to IDLE immediately.
  - DATA: each falling edge ends a high pulse of width w. w < BIT_MIN: ignored. BIT_MIN <= w < ONE_MIN: store 0 at bit_cnt, bit_cnt++. w >= ONE_MIN: store 1, bit_cnt++.
  - DATA -> DONE when the high width reaches GAP_END (frame_err=0), or when bit_cnt reaches MAX_BITS (frame_err=1).
  - DONE -> IDLE after one cycle. In DONE, with bit_cnt==0 the frame is discarded silently.
- Output register: load in the DONE cycle if frame_valid==0, or if frame_valid && frame_ready in that same cycle (accept and reload together). frame_valid rises the cycle after DONE.
- Otherwise the new frame is dropped and overrun pulses for one cycle; the held frame is unchanged.
- Handshake: frame_valid, once high, stays high with stable outputs until the cycle frame_valid && frame_ready; it clears next cycle unless reloaded.
- After MAX_BITS termination the FSM returns to IDLE, and further pulses of the same burst start lead detection anew.
- Arithmetic: widths compared unsigned at CNT_W; bit_cnt is LEN_W wide and never exceeds MAX_BITS.

Decomposition:
- Package ir_rx_pkg: FSM state enum (IDLE, LEAD, DATA, DONE) and default timing constants at 50 MHz.
- Sub-module ir_rx_filter (params FILT_LEN, INVERT): synchroniser + deglitch. Outputs filtered level plus rise/fall strobes.
- Width counter, FSM, bit buffer and output register live in the top.

Test Plan:
(Sim params: LEAD_MIN=40, LEAD_MAX=60, BIT_MIN=5, ONE_MIN=12, GAP_END=30, FILT_LEN=2, MAX_BITS=8.)
- 50-cycle low lead, then highs of 8,15,8,15 separated by 6-cycle lows, then idle high -> frame_valid, frame_len=4, frame_data=8'b0000_1010, frame_err=0.
- Lead of 30 or 70 cycles followed by data -> no frame_valid, busy returns 0.
- 1-cycle glitches on data_in during a high pulse -> ignored; 3-cycle high pulse inside DATA -> no bit stored.
- 10 pulses of width 15 -> frame_len=8, frame_data=8'hFF, frame_err=1.
- Two frames back-to-back with frame_ready=0 -> first held unchanged, overrun pulses once. Then ready=1 on the DONE cycle of a third frame -> accept and reload, no overrun.
- rst_n low for one clk mid-DATA -> all outputs 0, next clean frame received correctly.
